// File: rtl/qed_dup_sequencer.sv
// QED duplicate sequencer: issues constrained originals, then replays them remapped.
// Latency: one cycle from an accepted instruction to qed_ifu_instruction.
// Backpressure: ena=0 freezes every register, the FIFO and the outputs.

module qed_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Occupancy is tracked by the caller; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module qed_dup_sequencer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ifu_qed_instruction,
  input  logic             exec_dup,
  input  logic             ena,
  output logic [31:0]      qed_ifu_instruction,
  output logic             qed_vld_out,
  output logic             qed_exec_dup,
  output logic [CNT_W-1:0] qed_num_orig,
  output logic [CNT_W-1:0] qed_num_dup,
  output logic             qed_check_valid
);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0]  OP_MARK  = 7'b1111111;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_IALU  = 7'b0010011;
  localparam logic [6:0]  OP_FENCE = 7'b0001111;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ORIG, DUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic             vld_q, vld_d;
  logic             xdup_q, xdup_d;
  logic [CNT_W-1:0] norig_q, norig_d;
  logic [CNT_W-1:0] ndup_q, ndup_d;
  logic             chk_q, chk_d;
  logic             push, pop;
  logic [31:0]      head_dat;

  function automatic logic [4:0] reg_map(input logic [4:0] r);
    return (r == 5'd0) ? r : (r | 5'h10);
  endfunction

  // Duplicate register space is x17..x31; duplicate memory is the upper half (offset + 64).
  function automatic logic [31:0] remap(input logic [31:0] i);
    logic [31:0] r;
    r = i;
    case (i[6:0])
      OP_R: begin
        r[11:7]  = reg_map(i[11:7]);
        r[19:15] = reg_map(i[19:15]);
        r[24:20] = reg_map(i[24:20]);
      end
      OP_IALU, OP_FENCE: begin
        r[11:7]  = reg_map(i[11:7]);
        r[19:15] = reg_map(i[19:15]);
      end
      OP_LUI: r[11:7] = reg_map(i[11:7]);
      OP_BR: begin
        r[19:15] = reg_map(i[19:15]);
        r[24:20] = reg_map(i[24:20]);
      end
      OP_JALR: r[19:15] = reg_map(i[19:15]);
      OP_LOAD: begin
        r[11:7]  = reg_map(i[11:7]);
        r[19:15] = reg_map(i[19:15]);
        r[26]    = 1'b1;
      end
      // Store data register is kept; only the base register and the offset move.
      OP_STORE: begin
        r[19:15] = reg_map(i[19:15]);
        r[26]    = 1'b1;
      end
      default: r = i;
    endcase
    return r;
  endfunction

  qed_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (ifu_qed_instruction),
    .pop      (pop),
    .head_dat (head_dat)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    vld_d   = vld_q;
    xdup_d  = xdup_q;
    norig_d = norig_q;
    ndup_d  = ndup_q;
    chk_d   = chk_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (ena) begin
      case (state_q)
        ORIG: begin
          xdup_d = 1'b0;
          chk_d  = 1'b0;
          if (ifu_qed_instruction[6:0] == OP_MARK) begin
            inst_d = NOP_INST;
            vld_d  = 1'b0;
          end else begin
            inst_d  = ifu_qed_instruction;
            vld_d   = 1'b1;
            push    = 1'b1;
            norig_d = norig_q + 1'b1;
          end
          if ((exec_dup && norig_d != '0) || norig_d == FULL_CNT) state_d = DUP;
        end
        DUP: begin
          pop    = 1'b1;
          inst_d = remap(head_dat);
          vld_d  = 1'b1;
          xdup_d = 1'b1;
          ndup_d = ndup_q + 1'b1;
          if (ndup_d == norig_q) state_d = DONE;
        end
        DONE: begin
          inst_d = NOP_INST;
          vld_d  = 1'b0;
          xdup_d = 1'b1;
          chk_d  = 1'b1;
        end
        default: state_d = ORIG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ORIG;
      inst_q  <= NOP_INST;
      vld_q   <= 1'b0;
      xdup_q  <= 1'b0;
      norig_q <= '0;
      ndup_q  <= '0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      xdup_q  <= xdup_d;
      norig_q <= norig_d;
      ndup_q  <= ndup_d;
      chk_q   <= chk_d;
    end
  end

  assign qed_ifu_instruction = inst_q;
  assign qed_vld_out         = vld_q;
  assign qed_exec_dup        = xdup_q;
  assign qed_num_orig        = norig_q;
  assign qed_num_dup         = ndup_q;
  assign qed_check_valid     = chk_q;
endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer with hand-computed expected outputs.
module tb_qed_dup_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ifu_qed_instruction = 32'h0;
  logic        exec_dup = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] qed_ifu_instruction;
  logic        qed_vld_out;
  logic        qed_exec_dup;
  logic [4:0]  qed_num_orig;
  logic [4:0]  qed_num_dup;
  logic        qed_check_valid;

  int tests = 0;
  int fails = 0;

  qed_dup_sequencer #(.DEPTH(16), .CNT_W(5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ifu_qed_instruction (ifu_qed_instruction),
    .exec_dup            (exec_dup),
    .ena                 (ena),
    .qed_ifu_instruction (qed_ifu_instruction),
    .qed_vld_out         (qed_vld_out),
    .qed_exec_dup        (qed_exec_dup),
    .qed_num_orig        (qed_num_orig),
    .qed_num_dup         (qed_num_dup),
    .qed_check_valid     (qed_check_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [31:0] in, input logic ed);
    ena = e;
    ifu_qed_instruction = in;
    exec_dup = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst, input logic vld,
                            input logic xd, input int no, input int nd, input logic cv);
    chk({tag, "/inst"}, qed_ifu_instruction, inst);
    chk({tag, "/vld"}, 32'(qed_vld_out), 32'(vld));
    chk({tag, "/xdup"}, 32'(qed_exec_dup), 32'(xd));
    chk({tag, "/norig"}, 32'(qed_num_orig), 32'(no));
    chk({tag, "/ndup"}, 32'(qed_num_dup), 32'(nd));
    chk({tag, "/chk"}, 32'(qed_check_valid), 32'(cv));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    expect_out("reset", 32'h13, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] orig [16];
    logic [31:0] dupx [16];
    logic [4:0]  r;

    // Basic add + lw with exec_dup on the second original.
    do_reset();
    step(1, 32'h003100B3, 0); expect_out("b_o1", 32'h003100B3, 1, 0, 1, 0, 0);
    step(1, 32'h00802283, 1); expect_out("b_o2", 32'h00802283, 1, 0, 2, 0, 0);
    step(1, 32'h00000000, 0); expect_out("b_d1", 32'h013908B3, 1, 1, 2, 1, 0);
    step(1, 32'h00000000, 0); expect_out("b_d2", 32'h04802A83, 1, 1, 2, 2, 0);
    step(1, 32'h00000000, 0); expect_out("b_done", 32'h13, 0, 1, 2, 2, 1);
    step(1, 32'h003100B3, 1); expect_out("b_hold", 32'h13, 0, 1, 2, 2, 1);

    // NOP marker with exec_dup and no originals: ignored, stays in ORIG.
    do_reset();
    step(1, 32'h0000007F, 1); expect_out("m_nop", 32'h13, 0, 0, 0, 0, 0);
    step(1, 32'h00500093, 0); expect_out("m_o1", 32'h00500093, 1, 0, 1, 0, 0);
    // Stall with exec_dup high: ignored, nothing moves.
    step(0, 32'h00208133, 1); expect_out("m_stall", 32'h00500093, 1, 0, 1, 0, 0);
    step(1, 32'h00208133, 0); expect_out("m_o2", 32'h00208133, 1, 0, 2, 0, 0);
    step(1, 32'h00402223, 0); expect_out("m_o3", 32'h00402223, 1, 0, 3, 0, 0);
    step(1, 32'h00000073, 0); expect_out("m_o4", 32'h00000073, 1, 0, 4, 0, 0);
    step(1, 32'h00300063, 1); expect_out("m_o5", 32'h00300063, 1, 0, 5, 0, 0);
    // Duplicate phase with ena toggling 1/0.
    step(1, 32'h0, 0); expect_out("t_d1", 32'h00500893, 1, 1, 5, 1, 0);
    step(0, 32'h0, 0); expect_out("t_s1", 32'h00500893, 1, 1, 5, 1, 0);
    step(1, 32'h0, 0); expect_out("t_d2", 32'h01288933, 1, 1, 5, 2, 0);
    step(0, 32'h0, 0); expect_out("t_s2", 32'h01288933, 1, 1, 5, 2, 0);
    step(1, 32'h0, 0); expect_out("t_d3", 32'h04402223, 1, 1, 5, 3, 0);
    step(0, 32'h0, 0); expect_out("t_s3", 32'h04402223, 1, 1, 5, 3, 0);
    step(1, 32'h0, 0); expect_out("t_d4", 32'h00000073, 1, 1, 5, 4, 0);
    step(1, 32'h0, 0); expect_out("t_d5", 32'h01300063, 1, 1, 5, 5, 0);
    step(0, 32'h0, 0); expect_out("t_s5", 32'h01300063, 1, 1, 5, 5, 0);
    step(1, 32'h0, 0); expect_out("t_done", 32'h13, 0, 1, 5, 5, 1);

    // Sixteen originals force the duplicate phase without exec_dup.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      r = 5'((k % 15) + 1);
      orig[k] = {12'(k + 1), r, 3'b000, r, 7'b0010011};
      dupx[k] = {12'(k + 1), r | 5'h10, 3'b000, r | 5'h10, 7'b0010011};
    end
    for (int k = 0; k < 16; k++) begin
      step(1, orig[k], 0);
      expect_out($sformatf("f_o%0d", k), orig[k], 1, 0, k + 1, 0, 0);
    end
    for (int k = 0; k < 16; k++) begin
      step(1, 32'h00100093, 1);
      expect_out($sformatf("f_d%0d", k), dupx[k], 1, 1, 16, k + 1, 0);
    end
    step(1, 32'h00100093, 1); expect_out("f_done", 32'h13, 0, 1, 16, 16, 1);

    // Reset during DUP with three entries pending, then a fresh sequence.
    do_reset();
    step(1, 32'h003100B3, 0);
    step(1, 32'h00208133, 0);
    step(1, 32'h00500093, 0);
    step(1, 32'h00402223, 1); expect_out("r_o4", 32'h00402223, 1, 0, 4, 0, 0);
    step(1, 32'h0, 0);        expect_out("r_d1", 32'h013908B3, 1, 1, 4, 1, 0);
    rst_n = 1'b0;
    step(1, 32'h0, 0);        expect_out("r_rst", 32'h13, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 32'h00802283, 1); expect_out("r_o1", 32'h00802283, 1, 0, 1, 0, 0);
    step(1, 32'h0, 0);        expect_out("r_d1b", 32'h04802A83, 1, 1, 1, 1, 0);
    step(1, 32'h0, 0);        expect_out("r_done", 32'h13, 0, 1, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qed_dup_sequencer.md
Name: qed_dup_sequencer

Overview:
- Sits between the symbolic instruction source (already restricted by the instruction-constraint stage) and the CVA6 fetch interface.
- Original phase: forwards each constrained instruction to the core and records it in a FIFO.
- Duplicate phase: replays every recorded instruction with the register and memory spaces remapped.
- Asserts qed_check_valid once originals and duplicates balance, which gates the register-file and memory consistency checks.

Parameters:
- DEPTH, 16, FIFO entries; maximum originals per QED sequence (power of two).
- CNT_W, 5, width of the issue counters; must hold DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ifu_qed_instruction  in  32  constrained symbolic instruction
- exec_dup  in  1  free symbolic request to enter duplicate phase
- ena  in  1  fetch accepts an instruction this cycle; 0 = stall
- qed_ifu_instruction  out  32  instruction presented to fetch (registered)
- qed_vld_out  out  1  qed_ifu_instruction is a real issued instruction
- qed_exec_dup  out  1  1 while in DUP or DONE
- qed_num_orig  out  CNT_W  originals issued
- qed_num_dup  out  CNT_W  duplicates issued
- qed_check_valid  out  1  sequence complete; consistency check may fire

Behaviour:
- Single clock domain. All state updates on posedge clk.
- Reset (rst_n=0 at posedge) values:
  - state = ORIG, FIFO empty
  - qed_ifu_instruction = 32'h00000013 (addi x0,x0,0)
  - qed_vld_out = 0, qed_exec_dup = 0
  - counters = 0, qed_check_valid = 0
- Reset mid-sequence discards all FIFO contents and counts.
- ena=0: no state, FIFO, counter or output change. exec_dup is ignored that cycle.
- Latency: the instruction accepted at cycle N appears on qed_ifu_instruction at N+1.
- State ORIG, on ena=1:
  - Input opcode 7'b1111111 (NOP marker): output 32'h13, vld=0, no push, no count.
  - Any other input: output it unchanged, vld=1, push to FIFO, num_orig+1.
  - Go to DUP if (exec_dup && num_orig_next > 0) or FIFO becomes full (num_orig_next == DEPTH).
  - exec_dup together with a real instruction: that instruction is issued and counted first, then the switch happens.
  - exec_dup with num_orig == 0 and a NOP input: ignored.
- State DUP: input ignored. On ena=1:
  - Pop the FIFO head, output remap(head), vld=1, num_dup+1.
  - Go to DONE when the pop empties the FIFO.
- State DONE:
  - Output 32'h13, vld=0.
  - qed_check_valid = 1, registered, asserted the cycle after the last duplicate issues.
  - Held until reset.
- qed_exec_dup = 1 in DUP and DONE. It rises with the first duplicate output.
- remap(i), applied by opcode:
  - Register field rule: a nonzero register field gets bit 4 set (x1..x15 -> x17..x31); x0 stays x0.
  - R (0110011): rd, rs1, rs2.
  - I-ALU (0010011), FENCE (0001111): rd, rs1.
  - LUI (0110111): rd.
  - B (1100011): rs1, rs2.
  - JALR (1100111): rs1.
  - JAL and AUIPC: unchanged (rd=0).
  - Loads (0000011) and stores (0100011): register rule, plus set inst[26] (offset + 64, upper memory half).
  - SYSTEM (1110011): unchanged.
- Counter arithmetic: unsigned CNT_W. The invariant num_dup <= num_orig <= DEPTH guarantees no wrap.
- The FIFO never overflows; the full condition forces DUP. It never underflows; empty forces DONE.

Test Plan:
- Reset, then ena=1 with inputs 0x003100B3 (add x1,x2,x3) then exec_dup=1 on 0x00802283 (lw x5,8(x0)) -> outputs 0x003100B3, 0x00802283, then 0x013908B3, 0x04802A83; num_orig=num_dup=2; check_valid=1 the cycle after.
- ORIG with input 0x0000007F and exec_dup=1, num_orig=0 -> output 0x00000013, vld=0, stays ORIG, counters 0.
- Feed 16 real instructions, exec_dup=0 -> forced DUP after the 16th; 16 remapped outputs; then DONE, num_orig=num_dup=16.
- ena toggled 1/0 during DUP -> outputs and counters frozen on ena=0 cycles; duplicate order preserved; no skipped entries.
- Remap corner: beq x0,x3 (0x00300063) -> 0x01300063; sw x4,4(x0) (0x00402223) -> 0x04402223; ecall 0x00000073 unchanged.
- rst_n=0 during DUP with 3 entries pending -> next cycle state ORIG, outputs 0x13 / vld 0, counters 0; a new sequence runs correctly.
